// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with enable and bounded hold time.
// Registered one-hot grant plus encoded index, with a pulse on timeout pre-emption.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [1:0] idx_q;
    logic [7:0] hold_q;
    logic [3:0] gnt_q;
    logic       preempt_q;

    logic [2:0] idle_pick;
    logic [2:0] busy_pick;
    logic [1:0] succ;
    logic [3:0] owner_oh;
    logic       others_wait;
    logic       hold_expired;
    logic       hold_can_inc;

    // Returns {hit, index}: first asserted request scanning upward from start, mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start,
                                        input logic excl_en, input logic [1:0] excl);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (r[cand] && !(excl_en && (cand == excl))) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign succ         = idx_q + 2'd1;
    assign owner_oh     = 4'b0001 << idx_q;
    assign others_wait  = (req & ~owner_oh) != 4'b0000;
    assign idle_pick    = pick(req, ptr_q, 1'b0, 2'b00);
    // Owner is scanned last from succ, so excluding it only matters on pre-emption.
    assign busy_pick    = pick(req, succ, 1'b1, idx_q);
    assign hold_expired = (MAX_HOLD_L != 8'd0) && (hold_q >= MAX_HOLD_L);
    assign hold_can_inc = (hold_q != 8'hFF) && !hold_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            hold_q    <= 8'd0;
            gnt_q     <= 4'b0000;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && idle_pick[2]) begin
                        state_q <= BUSY;
                        idx_q   <= idle_pick[1:0];
                        gnt_q   <= 4'b0001 << idle_pick[1:0];
                        hold_q  <= 8'd1;
                    end
                end
                BUSY: begin
                    if (!en) begin
                        state_q <= IDLE;
                        ptr_q   <= succ;
                        idx_q   <= 2'd0;
                        gnt_q   <= 4'b0000;
                        hold_q  <= 8'd0;
                    end else if (!req[idx_q]) begin
                        ptr_q <= succ;
                        if (busy_pick[2]) begin
                            idx_q  <= busy_pick[1:0];
                            gnt_q  <= 4'b0001 << busy_pick[1:0];
                            hold_q <= 8'd1;
                        end else begin
                            state_q <= IDLE;
                            idx_q   <= 2'd0;
                            gnt_q   <= 4'b0000;
                            hold_q  <= 8'd0;
                        end
                    end else if (hold_expired && others_wait) begin
                        ptr_q     <= succ;
                        idx_q     <= busy_pick[1:0];
                        gnt_q     <= 4'b0001 << busy_pick[1:0];
                        hold_q    <= 8'd1;
                        preempt_q <= 1'b1;
                    end else if (hold_can_inc) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: two instances (MAX_HOLD=4 and unlimited) driven by
// directed vectors; expectations queued at drive time, checked by an independent monitor.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic       en_a, en_b;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b;
    logic       pre_a, pre_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         dut;
        logic [3:0] gnt;
        logic       pre;
        int         tag;
    } exp_t;

    exp_t sb[$];

    rr_arbiter4 #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a), .preempt(pre_a)
    );

    rr_arbiter4 #(.MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b), .preempt(pre_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        if (g[1]) r = 2'd1;
        if (g[2]) r = 2'd2;
        if (g[3]) r = 2'd3;
        return r;
    endfunction

    // Drive one cycle of inputs and queue what the addressed DUT must show after the edge.
    task automatic cyc(input bit d, input logic rs, input logic e, input logic [3:0] r,
                       input logic [3:0] eg, input logic ep, input int tag);
        exp_t x;
        @(negedge clk);
        rst = rs;
        if (d == 1'b0) begin
            en_a = e; req_a = r;
        end else begin
            en_b = e; req_b = r;
        end
        x.dut = d; x.gnt = eg; x.pre = ep; x.tag = tag;
        sb.push_back(x);
    endtask

    always begin
        exp_t x;
        logic [3:0] g;
        logic [1:0] ix;
        logic       v, p;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            g  = x.dut ? gnt_b   : gnt_a;
            ix = x.dut ? idx_b   : idx_a;
            v  = x.dut ? valid_b : valid_a;
            p  = x.dut ? pre_b   : pre_a;
            checks++;
            if (g !== x.gnt || ix !== enc(x.gnt) || v !== (|x.gnt) || p !== x.pre) begin
                errors++;
                $display("FAIL t%0d_dut%0d: got gnt=%b idx=%0d valid=%b pre=%b, required gnt=%b idx=%0d valid=%b pre=%b",
                         x.tag, x.dut, g, ix, v, p, x.gnt, enc(x.gnt), |x.gnt, x.pre);
            end else begin
                $display("ok   t%0d_dut%0d: gnt=%b idx=%0d valid=%b pre=%b",
                         x.tag, x.dut, g, ix, v, p);
            end
        end
    end

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; req_a = 4'b0; req_b = 4'b0;

        // Reset then idle
        cyc(0, 1, 0, 4'b0000, 4'b0000, 0, 1);
        cyc(0, 1, 0, 4'b0000, 4'b0000, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'b0000, 4'b0000, 0, 1);

        // Basic latency and encode
        cyc(0, 0, 1, 4'b0100, 4'b0100, 0, 2);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 0, 2);

        // Timeout pre-emption, MAX_HOLD=4
        cyc(0, 1, 0, 4'b0000, 4'b0000, 0, 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'b0101, 4'b0001, 0, 4);
        cyc(0, 0, 1, 4'b0101, 4'b0100, 1, 4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'b0101, 4'b0100, 0, 4);
        cyc(0, 0, 1, 4'b0101, 4'b0001, 1, 4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 4'b0001, 4'b0001, 0, 4);

        // Round-robin fairness, unlimited hold
        cyc(1, 1, 0, 4'b0000, 4'b0000, 0, 3);
        cyc(1, 0, 1, 4'b1111, 4'b0001, 0, 3);
        cyc(1, 0, 1, 4'b1111, 4'b0001, 0, 3);
        cyc(1, 0, 1, 4'b1110, 4'b0010, 0, 3);
        cyc(1, 0, 1, 4'b1111, 4'b0010, 0, 3);
        cyc(1, 0, 1, 4'b1101, 4'b0100, 0, 3);
        cyc(1, 0, 1, 4'b1111, 4'b0100, 0, 3);
        cyc(1, 0, 1, 4'b1011, 4'b1000, 0, 3);
        cyc(1, 0, 1, 4'b1111, 4'b1000, 0, 3);
        cyc(1, 0, 1, 4'b0111, 4'b0001, 0, 3);

        // Enable drop
        cyc(1, 1, 0, 4'b0000, 4'b0000, 0, 5);
        cyc(1, 0, 1, 4'b0010, 4'b0010, 0, 5);
        cyc(1, 0, 1, 4'b1111, 4'b0010, 0, 5);
        cyc(1, 0, 0, 4'b1111, 4'b0000, 0, 5);
        cyc(1, 0, 0, 4'b1111, 4'b0000, 0, 5);
        cyc(1, 0, 0, 4'b1111, 4'b0000, 0, 5);
        cyc(1, 0, 1, 4'b1111, 4'b0100, 0, 5);

        // Reset mid-operation
        cyc(1, 0, 1, 4'b1011, 4'b1000, 0, 6);
        cyc(1, 1, 1, 4'b1111, 4'b0000, 0, 6);
        cyc(1, 0, 1, 4'b1111, 4'b0001, 0, 6);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
Four-requester round-robin arbiter with enable and a bounded hold time. It shares one resource between four agents. It produces a registered one-hot grant plus its 2-bit encoded index, so downstream muxes can use either form. Grants are held while the owner keeps its request asserted. Once MAX_HOLD cycles have elapsed and another agent is waiting, the owner is pre-empted.

Parameters:
MAX_HOLD, 4, max consecutive grant cycles per ownership while others wait; 0 = unlimited hold; legal range 0..255

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  arbitration enable; low forces release and blocks new grants
req  input  4  request vector, bit i = requester i, level-sensitive
gnt  output  4  registered one-hot grant, all zeros when no owner
gnt_idx  output  2  encoded index of owner (0..3), 2'b00 when gnt_valid=0
gnt_valid  output  1  high while some requester owns the resource (equals |gnt)
preempt  output  1  one-cycle pulse, high in the first cycle of a grant won by timeout pre-emption

Behaviour:
- Reset (rst=1 at a clk edge) produces: gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, preempt=0, ptr=2'd0 (requester 0 highest priority), hold_cnt=0, state=IDLE. Reset overrides all other inputs, including mid-grant.
- State is ptr[1:0] (highest-priority index), hold_cnt[7:0], plus an FSM with states IDLE and BUSY.
- Selection function: scan req for an asserted bit at indices ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first hit wins. An excluded index, where one is specified, is skipped.
- IDLE state:
  - If en=1 and req!=0, the selection with no exclusion wins. On the next cycle: gnt=onehot(win), gnt_idx=win, gnt_valid=1, hold_cnt=1, state=BUSY, preempt=0.
  - Otherwise outputs stay zero.
  - Latency is req to gnt = 1 cycle.
- BUSY state, with owner o. The first matching rule applies each edge:
  1. en=0: release. gnt=0, gnt_valid=0, gnt_idx=0, ptr=o+1, state=IDLE. No new grant is issued that edge.
  2. req[o]=0 (voluntary release): set ptr=o+1 and run selection on the current req from o+1.
     - On a hit, switch directly with no idle cycle: gnt=onehot(win), hold_cnt=1, preempt=0.
     - On no hit, go to IDLE with outputs zero.
  3. MAX_HOLD!=0, hold_cnt>=MAX_HOLD, and (req & ~onehot(o))!=0 (pre-emption): select from o+1 excluding o. Then gnt=onehot(win), hold_cnt=1, ptr=o+1, preempt=1 for exactly this one cycle.
  4. Otherwise keep the grant. hold_cnt increments, saturating at 255; it also stops at MAX_HOLD when MAX_HOLD!=0. preempt=0.
- preempt is 0 in every cycle not entered through rule 3.
- gnt is always zero or exactly one-hot. gnt_idx always matches gnt. gnt_valid is always |gnt.
- The pointer wraps 3 to 0. ptr changes only on release or pre-emption, never on a plain hold.
- A requester that drops req does not lose its place in the rotation. Priority depends only on ptr.
- MAX_HOLD=1 with all four requesters asserted gives a strict rotation, one grant per cycle, with preempt=1 on every cycle after the first grant.
- en=1 with req=0 in IDLE has no state change.
- If en is low at the same edge that req[o] drops, rule 1 applies.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0, en=1, req=0 -> gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0 on every cycle.
- Basic latency and encode: en=1, req=0100 sampled at edge N -> at N+1 gnt=0100, gnt_idx=10, gnt_valid=1. Then req=0000 -> next cycle gnt=0000, gnt_valid=0.
- Round-robin fairness: MAX_HOLD=0, req=1111, each owner drops its req for one cycle after 2 grant cycles. Required grant order from reset is idx 0, 1, 2, 3, 0, with back-to-back switches and no gap cycle.
- Timeout pre-emption: MAX_HOLD=4, req=0101 held constant from reset.
  - gnt=0001 for exactly 4 cycles.
  - Then gnt=0100 with preempt=1 for one cycle.
  - After 4 more cycles, gnt=0001 with preempt=1.
  - With req=0001 alone, the grant is held indefinitely and preempt stays 0.
- Enable drop: mid-grant with gnt=0010, drive en=0 -> next cycle gnt=0000, gnt_valid=0. With req=1111 held, no grant appears while en=0. When en returns to 1, the first grant is idx 2, because ptr advanced past 1.
- Reset mid-operation: with gnt=1000 and ptr advanced, assert rst for 1 cycle while req=1111 -> outputs zero that cycle. With en=1, the next grant after deassertion is idx 0.
